// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp, funct3/funct7 values,
// M-extension operation codes and FSM state constants.
package alu_pkg;

    localparam logic [1:0] ALUOP_RI  = 2'b00;
    localparam logic [1:0] ALUOP_MEM = 2'b01;
    localparam logic [1:0] ALUOP_BR  = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_op_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic is_mext(input logic [1:0] aluop, input logic [6:0] funct7);
        return (aluop == ALUOP_RI) && (funct7 == F7_MEXT);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M datapath: one shift-add or restoring-divide step per cycle
// on operand magnitudes, with the sign correction applied on the way out.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             step,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH);

    m_op_e            op_p0;
    logic             neg_p0;
    logic             neg_rem_p0;
    logic             div0_p0;
    logic [WIDTH-1:0] hi_p0;
    logic [WIDTH-1:0] lo_p0;
    logic [WIDTH-1:0] dvs_p0;
    logic [CNT_W-1:0] cnt_p0;

    m_op_e            op_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             is_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign op_in = m_op_e'(funct3);
    assign a_neg = a[WIDTH-1] & (op_in inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM});
    assign b_neg = b[WIDTH-1] & (op_in inside {M_MUL, M_MULH, M_DIV, M_REM});
    assign a_mag = neg_w(a, a_neg);
    assign b_mag = neg_w(b, b_neg);

    assign is_div    = op_p0[2];
    assign mul_sum   = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, dvs_p0} : '0);
    assign div_trial = {hi_p0, lo_p0[WIDTH-1]} - {1'b0, dvs_p0};
    assign last      = (cnt_p0 == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_p0 <= '0;
        end else if (start) begin
            cnt_p0 <= '0;
        end else if (step) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // p0: capture magnitudes at acceptance, then iterate hi:lo in place
    always_ff @(posedge clk) begin
        if (start) begin
            op_p0      <= op_in;
            neg_p0     <= a_neg ^ b_neg;
            neg_rem_p0 <= a_neg;
            div0_p0    <= (b == '0);
            hi_p0      <= '0;
            lo_p0      <= op_in[2] ? a_mag : b_mag;
            dvs_p0     <= op_in[2] ? b_mag : a_mag;
        end else if (step) begin
            if (is_div) begin
                if (!div_trial[WIDTH]) begin
                    hi_p0 <= div_trial[WIDTH-1:0];
                    lo_p0 <= {lo_p0[WIDTH-2:0], 1'b1};
                end else begin
                    hi_p0 <= {hi_p0[WIDTH-2:0], lo_p0[WIDTH-1]};
                    lo_p0 <= {lo_p0[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_p0 <= mul_sum[WIDTH:1];
                lo_p0 <= {mul_sum[0], lo_p0[WIDTH-1:1]};
            end
        end
    end

    // A zero divisor leaves an all-ones magnitude quotient and |A| as remainder;
    // only the quotient needs forcing, the remainder sign fix restores A.
    assign prod = neg_2w({hi_p0, lo_p0}, neg_p0);
    assign quo  = div0_p0 ? '1 : neg_w(lo_p0, neg_p0);
    assign rem  = neg_w(hi_p0, neg_rem_p0);
    assign div0 = is_div & div0_p0;

    always_comb begin
        result = '0;
        case (op_p0)
            M_MUL:                     result = prod[WIDTH-1:0];
            M_MULH, M_MULHSU, M_MULHU: result = prod[2*WIDTH-1:WIDTH];
            M_DIV, M_DIVU:             result = quo;
            M_REM, M_REMU:             result = rem;
            default:                   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative RV32M ops behind
// a valid/ready handshake, with a flush input for in-flight M ops.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             Rstn_i,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic             Kill_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [2:0]       Funct3_i,
    input  logic [6:0]       Funct7_i,
    input  logic [WIDTH-1:0] OperandA_i,
    input  logic [WIDTH-1:0] OperandB_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Flag_o,
    output logic             Valid_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [1:0]        state_p0;
    logic              accept;
    logic              is_m;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_flag;
    logic              md_last;
    logic [WIDTH-1:0]  md_result;
    logic              md_div0;

    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return a < b;
            F3_BGE:  return a >= b;
            F3_BLTU: return $unsigned(a) < $unsigned(b);
            F3_BGEU: return $unsigned(a) >= $unsigned(b);
            default: return 1'b0;
        endcase
    endfunction

    assign Ready_o = (state_p0 == ST_IDLE) & ~Kill_i;
    assign accept  = Valid_i & Ready_o;
    assign is_m    = is_mext(ALUOp_i, Funct7_i);
    assign a_s     = OperandA_i;
    assign b_s     = OperandB_i;
    assign sum     = OperandA_i + OperandB_i;
    assign diff    = OperandA_i - OperandB_i;
    assign shamt   = OperandB_i[SH_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (ALUOp_i)
            ALUOP_RI: begin
                case (Funct3_i)
                    F3_ADD:  alu_res = Funct7_i[5] ? diff : sum;
                    F3_SLL:  alu_res = OperandA_i << shamt;
                    F3_SLT:  alu_res = WIDTH'(a_s < b_s);
                    F3_SLTU: alu_res = WIDTH'(OperandA_i < OperandB_i);
                    F3_XOR:  alu_res = OperandA_i ^ OperandB_i;
                    F3_SR:   alu_res = Funct7_i[5] ? WIDTH'(a_s >>> shamt) : (OperandA_i >> shamt);
                    F3_OR:   alu_res = OperandA_i | OperandB_i;
                    F3_AND:  alu_res = OperandA_i & OperandB_i;
                    default: alu_res = '0;
                endcase
            end
            ALUOP_MEM: alu_res = sum;
            ALUOP_BR: begin
                alu_res  = diff;
                alu_flag = br_taken(Funct3_i, a_s, b_s);
            end
            ALUOP_LUI: alu_res = OperandB_i;
            default:   alu_res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (Clk_i),
        .rstn   (Rstn_i),
        .start  (accept & is_m),
        .step   (state_p0 == ST_CALC),
        .funct3 (Funct3_i),
        .a      (OperandA_i),
        .b      (OperandB_i),
        .last   (md_last),
        .result (md_result),
        .div0   (md_div0)
    );

    // p0: FSM and output registers; Kill_i overrides every state
    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            state_p0 <= ST_IDLE;
            Result_o <= '0;
            Flag_o   <= 1'b0;
            Valid_o  <= 1'b0;
        end else begin
            Valid_o <= 1'b0;
            if (Kill_i) begin
                state_p0 <= ST_IDLE;
            end else begin
                case (state_p0)
                    ST_IDLE: begin
                        if (Valid_i) begin
                            if (is_m) begin
                                state_p0 <= ST_CALC;
                            end else begin
                                Result_o <= alu_res;
                                Flag_o   <= alu_flag;
                                Valid_o  <= 1'b1;
                            end
                        end
                    end
                    ST_CALC: begin
                        if (md_last) state_p0 <= ST_FIX;
                    end
                    ST_FIX: begin
                        Result_o <= md_result;
                        Flag_o   <= md_div0;
                        Valid_o  <= 1'b1;
                        state_p0 <= ST_IDLE;
                    end
                    default: state_p0 <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=32): requests push expected
// result/flag/edge-offset into a queue that a negedge monitor drains.
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         Clk_i = 1'b0;
    logic         Rstn_i;
    logic         Valid_i;
    logic         Ready_o;
    logic         Kill_i;
    logic [1:0]   ALUOp_i;
    logic [2:0]   Funct3_i;
    logic [6:0]   Funct7_i;
    logic [W-1:0] OperandA_i;
    logic [W-1:0] OperandB_i;
    logic [W-1:0] Result_o;
    logic         Flag_o;
    logic         Valid_o;

    alu_seq_unit #(.WIDTH(W)) dut (
        .Clk_i      (Clk_i),
        .Rstn_i     (Rstn_i),
        .Valid_i    (Valid_i),
        .Ready_o    (Ready_o),
        .Kill_i     (Kill_i),
        .ALUOp_i    (ALUOp_i),
        .Funct3_i   (Funct3_i),
        .Funct7_i   (Funct7_i),
        .OperandA_i (OperandA_i),
        .OperandB_i (OperandB_i),
        .Result_o   (Result_o),
        .Flag_o     (Flag_o),
        .Valid_o    (Valid_o)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         flag;
        int           acc;
        int           dly;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_res;

    always @(posedge Clk_i) cyc = cyc + 1;

    // Monitor: every Valid_o pulse must match the oldest outstanding request.
    always @(negedge Clk_i) begin
        if (Valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_valid observed Result=%h Flag=%b with no request outstanding", Result_o, Flag_o);
            end else begin
                mon_e = sb.pop_front();
                n_vec++;
                assert (Result_o === mon_e.res) else begin
                    n_err++;
                    $error("FAIL %s_result observed=%h expected=%h", mon_e.tag, Result_o, mon_e.res);
                end
                n_vec++;
                assert (Flag_o === mon_e.flag) else begin
                    n_err++;
                    $error("FAIL %s_flag observed=%b expected=%b", mon_e.tag, Flag_o, mon_e.flag);
                end
                n_vec++;
                assert ((cyc - mon_e.acc) === mon_e.dly) else begin
                    n_err++;
                    $error("FAIL %s_latency observed=%0d expected=%0d", mon_e.tag, cyc - mon_e.acc, mon_e.dly);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp_i    = op;
        Funct3_i   = f3;
        Funct7_i   = f7;
        OperandA_i = a;
        OperandB_i = b;
        Valid_i    = 1'b1;
    endtask

    // dly = edges from the accepting edge to the edge that raises Valid_o
    task automatic send(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic flag, input int dly);
        exp_t e;
        @(negedge Clk_i);
        n_vec++;
        assert (Ready_o === 1'b1) else begin
            n_err++;
            $error("FAIL %s_ready observed=%b expected=1", tag, Ready_o);
        end
        drive(op, f3, f7, a, b);
        e.tag  = tag;
        e.res  = res;
        e.flag = flag;
        e.acc  = cyc + 1;
        e.dly  = dly;
        sb.push_back(e);
        last_res = res;
        @(posedge Clk_i);
        #1 Valid_i = 1'b0;
    endtask

    task automatic busy_check(input string tag);
        logic ok = 1'b1;
        repeat (W + 1) begin
            @(negedge Clk_i);
            if (Ready_o !== 1'b0 || Valid_o !== 1'b0) ok = 1'b0;
        end
        n_vec++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s_busy observed Ready_o/Valid_o activity during CALC expected both 0", tag);
        end
    endtask

    task automatic send_m(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res, input logic flag);
        send(tag, 2'b00, f3, 7'b0000001, a, b, res, flag, W + 1);
        busy_check(tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clk_i);
            n++;
        end
        n_vec++;
        assert (sb.size() === 0) else begin
            n_err++;
            $error("FAIL %s_drain observed %0d outstanding expected 0", tag, sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rstn_i = 1'b0; Valid_i = 1'b0; Kill_i = 1'b0;
        ALUOp_i = '0; Funct3_i = '0; Funct7_i = '0; OperandA_i = '0; OperandB_i = '0;
        repeat (3) @(posedge Clk_i);
        @(negedge Clk_i);
        n_vec++; assert (Result_o === 32'h0) else begin n_err++; $error("FAIL rst_result observed=%h expected=0", Result_o); end
        n_vec++; assert (Flag_o === 1'b0) else begin n_err++; $error("FAIL rst_flag observed=%b expected=0", Flag_o); end
        n_vec++; assert (Valid_o === 1'b0) else begin n_err++; $error("FAIL rst_valid observed=%b expected=0", Valid_o); end
        n_vec++; assert (Ready_o === 1'b1) else begin n_err++; $error("FAIL rst_ready observed=%b expected=1", Ready_o); end
        Rstn_i = 1'b1;

        // back-to-back single-cycle ops
        send("sub",    2'b00, 3'b000, 7'b0100000, 32'd20, -32'sd30, 32'd50, 1'b0, 0);
        send("sra",    2'b00, 3'b101, 7'b0100000, -32'sd20, 32'd2, -32'sd5, 1'b0, 0);
        send("sltu",   2'b00, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        send("slt",    2'b00, 3'b010, 7'b0000000, -32'sd1, 32'd1, 32'd1, 1'b0, 0);
        send("sll31",  2'b00, 3'b001, 7'b0000000, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0, 0);
        send("srl",    2'b00, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 0);
        send("xor",    2'b00, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 0);
        send("and",    2'b00, 3'b111, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 0);
        send("or",     2'b00, 3'b110, 7'b0000000, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 0);
        send("ldst",   2'b01, 3'b111, 7'b0100000, 32'd1000, -32'sd8, 32'd992, 1'b0, 0);
        // branch compares
        send("blt",    2'b10, 3'b100, 7'b0000000, -32'sd1, 32'd1, 32'hFFFF_FFFE, 1'b1, 0);
        send("bltu",   2'b10, 3'b110, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 0);
        send("beq",    2'b10, 3'b000, 7'b0000000, 32'd20, 32'd20, 32'd0, 1'b1, 0);
        send("bne",    2'b10, 3'b001, 7'b0000000, 32'd20, 32'd20, 32'd0, 1'b0, 0);
        send("bge",    2'b10, 3'b101, 7'b0000000, 32'd5, -32'sd3, 32'd8, 1'b1, 0);
        send("bgeu",   2'b10, 3'b111, 7'b0000000, 32'd5, -32'sd3, 32'd8, 1'b0, 0);
        send("br010",  2'b10, 3'b010, 7'b0000000, 32'd7, 32'd7, 32'd0, 1'b0, 0);
        drain("single");

        // multiply
        send_m("mul",    3'b000, -32'sd7, 32'd6, -32'sd42, 1'b0);
        send_m("mulh",   3'b001, -32'sd7, 32'd6, 32'hFFFF_FFFF, 1'b0);
        send_m("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        send_m("mulhsu", 3'b010, -32'sd1, 32'd2, 32'hFFFF_FFFF, 1'b0);
        // divide
        send_m("div",    3'b100, -32'sd20, 32'd3, -32'sd6, 1'b0);
        send_m("rem",    3'b110, -32'sd20, 32'd3, -32'sd2, 1'b0);
        send_m("divu0",  3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
        send_m("remu0",  3'b111, 32'd100, 32'd0, 32'd100, 1'b1);
        send_m("divs0",  3'b100, -32'sd7, 32'd0, 32'hFFFF_FFFF, 1'b1);
        send_m("rems0",  3'b110, -32'sd7, 32'd0, -32'sd7, 1'b1);
        send_m("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        send_m("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        send("lui", 2'b11, 3'b000, 7'b0000000, 32'd9, 32'h1234_5000, 32'h1234_5000, 1'b0, 0);
        drain("mdiv");

        // kill an in-flight divide ten cycles in
        @(negedge Clk_i);
        drive(2'b00, 3'b100, 7'b0000001, 32'd100, 32'd7);
        @(posedge Clk_i);
        #1 Valid_i = 1'b0;
        repeat (10) @(negedge Clk_i);
        Kill_i = 1'b1;
        #1;
        n_vec++; assert (Ready_o === 1'b0) else begin n_err++; $error("FAIL kill_ready_low observed=%b expected=0", Ready_o); end
        @(posedge Clk_i);
        #1 Kill_i = 1'b0;
        @(negedge Clk_i);
        n_vec++; assert (Ready_o === 1'b1) else begin n_err++; $error("FAIL kill_idle observed=%b expected=1", Ready_o); end
        n_vec++; assert (Valid_o === 1'b0) else begin n_err++; $error("FAIL kill_valid observed=%b expected=0", Valid_o); end
        n_vec++; assert (Result_o === last_res) else begin n_err++; $error("FAIL kill_hold observed=%h expected=%h", Result_o, last_res); end
        repeat (40) @(negedge Clk_i);
        send("add_after_kill", 2'b00, 3'b000, 7'b0000000, 32'd2, 32'd3, 32'd5, 1'b0, 0);
        drain("kill");

        // reset in the middle of a multiply
        @(negedge Clk_i);
        drive(2'b00, 3'b000, 7'b0000001, 32'd123, 32'd456);
        @(posedge Clk_i);
        #1 Valid_i = 1'b0;
        repeat (5) @(negedge Clk_i);
        Rstn_i = 1'b0;
        @(negedge Clk_i);
        n_vec++; assert (Result_o === 32'h0) else begin n_err++; $error("FAIL rstmid_result observed=%h expected=0", Result_o); end
        n_vec++; assert (Valid_o === 1'b0) else begin n_err++; $error("FAIL rstmid_valid observed=%b expected=0", Valid_o); end
        n_vec++; assert (Ready_o === 1'b1) else begin n_err++; $error("FAIL rstmid_ready observed=%b expected=1", Ready_o); end
        Rstn_i = 1'b1;
        repeat (45) @(negedge Clk_i);
        n_vec++; assert (Result_o === 32'h0) else begin n_err++; $error("FAIL rstmid_stale observed=%h expected=0", Result_o); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the single-cycle ALU/ALU-control pair: decodes ALUOp/Funct3/Funct7 and executes RV32I arithmetic, logic, shift, compare, branch-condition and LUI operations in one registered cycle, plus RV32M multiply/divide/remainder iteratively over WIDTH cycles. Sits in the execute stage between the operand-forwarding muxes and the EX/MEM register; the stage stalls on Ready_o low.

## Interface
- WIDTH, 32: datapath width (power of two, ≥8)
- Clk_i  in  1  clock, rising edge
- Rstn_i  in  1  synchronous, active-low reset
- Valid_i  in  1  request valid; accepted when Valid_i & Ready_o at a rising edge
- Ready_o  out  1  unit can accept a request this cycle
- Kill_i  in  1  abort any in-flight multi-cycle op (pipeline flush)
- ALUOp_i  in  2  00 R/I-type, 01 load/store address, 10 branch compare, 11 LUI
- Funct3_i  in  3  instruction funct3
- Funct7_i  in  7  instruction funct7 (0000000 base, 0100000 SUB/SRA, 0000001 M-extension)
- OperandA_i  in  WIDTH  source A
- OperandB_i  in  WIDTH  source B / immediate
- Result_o  out  WIDTH  registered result, held until next completion
- Flag_o  out  1  branch taken (ALUOp 10) or divide-by-zero (M div/rem); else 0
- Valid_o  out  1  one-cycle pulse: Result_o/Flag_o updated this cycle

## Operation
- ALUOp 00, Funct7 ≠ 0000001: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND by Funct3; shift amount = OperandB_i[log2(WIDTH)-1:0].
- ALUOp 01: A+B regardless of funct fields. ALUOp 11: Result = B.
- ALUOp 10: Result = A−B; Flag by Funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 give Flag 0.
- ALUOp 00, Funct7 0000001: Funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply: operands converted to magnitudes, unsigned shift-add, 2·WIDTH product, sign fixed in FIX. Divide: restoring, magnitudes, quotient/remainder signs fixed in FIX (remainder takes dividend sign).
- Divide by zero: quotient all-ones, remainder = A, Flag_o 1. Signed overflow (most-negative / −1): quotient = A, remainder 0, Flag_o 0.
- FSM: IDLE (Ready_o 1) → on accepted M op → CALC, counter 0; CALC steps once per cycle, counter WIDTH−1 → FIX; FIX registers result, pulses Valid_o, → IDLE. Non-M ops never leave IDLE.
- Kill_i: any state → IDLE next edge, no Valid_o for the killed op; Ready_o forced 0 while Kill_i high, so no request accepted that cycle.
- Reset: state IDLE, counter 0, Result_o 0, Flag_o 0, Valid_o 0; reset mid-CALC discards the op.

## Timing
- Ready_o = (state==IDLE) & ~Kill_i, combinational from state.
- Non-M op accepted at edge n: Valid_o high in cycle after edge n (latency 1); back-to-back every cycle.
- M op accepted at edge n: CALC edges n+1..n+WIDTH, FIX edge n+WIDTH+1; Valid_o high in the cycle after edge n+WIDTH+1 (latency WIDTH+1; 33 for WIDTH=32).
- Ready_o is high during the Valid_o cycle; a new request may be accepted on that same edge.
- Operands/functs captured at acceptance; inputs may change during CALC.

## Structure
- Package alu_pkg: ALUOp encodings, Funct3 constants (base, branch, M), Funct7 constants, FSM state enum.
- Sub-module muldiv_iter: iterative multiply/divide datapath (operand regs, shift registers, counter, sign fix); top holds decode, single-cycle datapath, FSM and output registers.

## Test plan (WIDTH=32)
- Back-to-back single-cycle: SUB 20−(−30) → 50; SRA −20>>2 → −5; SLTU 1,0xFFFFFFFF → 1; Valid_o every cycle, Ready_o constant 1.
- Branch: BLT −1,1 → Flag 1; BLTU 0xFFFFFFFF,1 → Flag 0; BEQ 20,20 → Flag 1, Result 0.
- Multiply: MUL −7×6 → −42; MULHU 0xFFFFFFFF² → 0xFFFFFFFE; MULHSU −1×2 → 0xFFFFFFFF; each Valid_o exactly 33 cycles after accept, Ready_o low in between.
- Divide: DIV −20/3 → −6; REM −20/3 → −2; DIVU 100/0 → 0xFFFFFFFF, Flag 1; REMU 100/0 → 100; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Kill_i asserted 10 cycles into DIV → IDLE next cycle, no Valid_o, Result_o unchanged; following ADD 2+3 → 5 at latency 1.
- Rstn_i low mid-MUL → next cycle Result_o 0, Valid_o 0, Ready_o 1; no stale Valid_o afterwards.
